wall_scan_ctrl: RTL
===================

Name: wall_scan_ctrl

Overview:
Per-frame sequencer that walks the wall table, checks each enabled wall against the player (CY) position, and ORs the results into one 4-bit blocked-direction mask. Sits between the frame-tick logic, the wall-table RAM/ROM, and the player movement logic. Movement requests are gated by the registered mask, so CY cannot step into any wall.

Parameters:
N_WALLS, 32, number of wall table entries scanned per frame
ADDR_W, 5, wall table address width; must satisfy 2^ADDR_W >= N_WALLS
TILE, 20, wall/player edge length in pixels

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  frame tick; begins a scan when in IDLE
pos_h_CY  in  10  player x, latched at start
pos_v_CY  in  10  player y, latched at start
wall_rd_en  out  1  table read strobe
wall_addr  out  ADDR_W  table read address
wall_h  in  10  wall x; valid the cycle after wall_rd_en
wall_v  in  10  wall y; valid the cycle after wall_rd_en
wall_en  in  1  entry enabled; valid with wall_h/wall_v
busy  out  1  scan in progress
done  out  1  one-cycle pulse; collision updated this cycle
collision  out  4  bit0 blocked-left, bit1 blocked-right, bit2 blocked-down, bit3 blocked-up
move_req  in  4  requested moves, same bit order
move_grant  out  4  move_req & ~collision (combinational)

Behaviour:
- Reset: state IDLE; busy=0, done=0, wall_rd_en=0, wall_addr=0, collision=0, accumulator=0, latched position=0.
- Clock start-sampling cycle as cycle 0.
- IDLE: start=1 -> latch pos_h_CY/pos_v_CY, clear accumulator, go SCAN.
- SCAN, cycles 1..N_WALLS: wall_rd_en=1; wall_addr=0..N_WALLS-1, one per cycle, no gaps.
- Read data for address a arrives in cycle a+2. At that cycle's edge, if wall_en=1, OR the per-wall result into the accumulator. Disabled entries contribute 0.
- DRAIN, cycle N_WALLS+1: wall_rd_en=0; last data is accumulated.
- DONE, cycle N_WALLS+2: collision <= accumulator at the edge entering DONE; done=1 for exactly this cycle; next state IDLE.
- busy=1 in cycles 1..N_WALLS+2 inclusive.
- start is ignored while busy, including in the DONE cycle.
- A start arriving one cycle after done begins a new scan.
- collision holds its value between scans. It never shows partial results.
- Per-wall rule: all arithmetic widened to 11 bits unsigned, with no subtraction, so there is no underflow at coordinate 0.
  - Vertical overlap: pv+TILE > wv AND pv < wv+TILE.
  - Horizontal overlap: ph+TILE > wh AND ph < wh+TILE.
  - Given vertical overlap: ph == wh+TILE -> bit0; ph+TILE == wh -> bit1.
  - Given horizontal overlap: pv+TILE == wv -> bit2; pv == wv+TILE -> bit3.
  - Diagonal corner contact (no overlap on either axis) -> 0.
- rst mid-scan: return to IDLE on the next edge with all reset values; no done pulse; collision=0.
- move_grant follows move_req combinationally against the registered collision.

Decomposition:
- Shared package wall_pkg holds:
  - TILE constant
  - collision bit indices COL_LEFT=0, COL_RIGHT=1, COL_DOWN=2, COL_UP=3
  - state encoding IDLE/SCAN/DRAIN/DONE
- One combinational sub-module, wall_adjacency: inputs are player position and wall position; output is the 4-bit per-wall result per the rule above.
- wall_scan_ctrl holds the FSM, address counter, read-valid pipeline flag, accumulator and output register.

Test Plan:
(bench N_WALLS=4, single-cycle-latency table model, player (100,100) unless stated)
- Walls (120,100),(80,100),(100,120),(100,80), all enabled; start at cycle 0 -> done only in cycle 6; busy cycles 1-6; collision=4'b1111; move_req=4'b1111 -> move_grant=4'b0000.
- Only wall (120,100) enabled, the rest wall_en=0 -> collision=4'b0010; move_req=4'b0011 -> move_grant=4'b0001.
- Boundary: player (0,20), wall (0,0) -> collision=4'b1000. Player (20,0), wall (0,0) -> 4'b0001. Diagonal wall (120,120) alone -> 4'b0000.
- Second start pulse at cycle 3 and at cycle 6 -> both ignored, single done. Player position changed in cycle 2 -> result uses the position latched at cycle 0.
- rst asserted in cycle 3 -> cycle 4: busy=0, wall_rd_en=0, collision=0, no done. A new start afterwards completes normally with done in cycle 6 relative to that start.

Source files
------------

// File: rtl/wall_pkg.sv
// Shared constants and FSM encoding for the per-frame wall collision scan.
package wall_pkg;

  localparam int unsigned TILE = 20;

  localparam int COL_LEFT  = 0;
  localparam int COL_RIGHT = 1;
  localparam int COL_DOWN  = 2;
  localparam int COL_UP    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/wall_adjacency.sv
// Combinational contact test between the player tile and one wall tile.
module wall_adjacency
  import wall_pkg::*;
#(
  parameter int unsigned TILE_PX = TILE
) (
  input  logic [9:0] ph,
  input  logic [9:0] pv,
  input  logic [9:0] wh,
  input  logic [9:0] wv,
  output logic [3:0] adj
);

  // Everything is compared as sums in 11 bits so a coordinate of 0 never wraps.
  logic [10:0] tile_w;
  logic [10:0] ph_w, pv_w, wh_w, wv_w;
  logic [10:0] ph_end, pv_end, wh_end, wv_end;
  logic        h_ovl, v_ovl;

  assign tile_w = 11'(TILE_PX);
  assign ph_w   = {1'b0, ph};
  assign pv_w   = {1'b0, pv};
  assign wh_w   = {1'b0, wh};
  assign wv_w   = {1'b0, wv};
  assign ph_end = ph_w + tile_w;
  assign pv_end = pv_w + tile_w;
  assign wh_end = wh_w + tile_w;
  assign wv_end = wv_w + tile_w;

  assign v_ovl = (pv_end > wv_w) && (pv_w < wv_end);
  assign h_ovl = (ph_end > wh_w) && (ph_w < wh_end);

  // NOTE: default every output first so no path through the block infers a latch.
  always_comb begin
    adj = 4'b0000;
    if (v_ovl) begin
      adj[COL_LEFT]  = (ph_w == wh_end);
      adj[COL_RIGHT] = (ph_end == wh_w);
    end
    if (h_ovl) begin
      adj[COL_DOWN] = (pv_end == wv_w);
      adj[COL_UP]   = (pv_w == wv_end);
    end
  end

endmodule

// File: rtl/wall_scan_ctrl.sv
// Walks the wall table once per frame tick and publishes the blocked-direction
// mask; movement requests are gated against the last completed scan.
module wall_scan_ctrl
  import wall_pkg::*;
#(
  parameter int N_WALLS = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [9:0]        pos_h_CY,
  input  logic [9:0]        pos_v_CY,
  output logic              wall_rd_en,
  output logic [ADDR_W-1:0] wall_addr,
  input  logic [9:0]        wall_h,
  input  logic [9:0]        wall_v,
  input  logic              wall_en,
  output logic              busy,
  output logic              done,
  output logic [3:0]        collision,
  input  logic [3:0]        move_req,
  output logic [3:0]        move_grant
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WALLS - 1);

  state_t     state;
  logic [9:0] ph_q, pv_q;
  logic       rd_valid;
  logic [3:0] acc;
  logic [3:0] wall_adj;
  logic [3:0] wall_contrib;

  wall_adjacency #(.TILE_PX(TILE)) u_adj (
    .ph  (ph_q),
    .pv  (pv_q),
    .wh  (wall_h),
    .wv  (wall_v),
    .adj (wall_adj)
  );

  // Read data trails the strobe by one cycle; only those cycles carry a wall.
  assign wall_contrib = (rd_valid && wall_en) ? wall_adj : 4'b0000;
  assign move_grant   = move_req & ~collision;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ph_q       <= '0;
      pv_q       <= '0;
      rd_valid   <= 1'b0;
      acc        <= '0;
      wall_rd_en <= 1'b0;
      wall_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      collision  <= '0;
    end else begin
      rd_valid <= wall_rd_en;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ph_q       <= pos_h_CY;
            pv_q       <= pos_v_CY;
            acc        <= '0;
            wall_rd_en <= 1'b1;
            wall_addr  <= '0;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          acc <= acc | wall_contrib;
          if (wall_addr == LAST_ADDR) begin
            wall_rd_en <= 1'b0;
            state      <= DRAIN;
          end else begin
            wall_addr <= wall_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Fold the final read in directly so collision only ever sees a full scan.
          collision <= acc | wall_contrib;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
